// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Parity build option: UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: pulses o_bit_done on the last clk of each bit.
// Restarts from zero whenever i_clear is high.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign o_bit_done = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (i_reset || i_clear || o_bit_done)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready word intake.
// Parity bit present only when UART_TX_PARITY_EN is defined.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy
);

  localparam int BMAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BW = cnt_w(BMAX);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  uart_tx_state_e    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              bit_done;
  logic              last_stop;
  logic              hs;
  logic              clear;

  assign last_stop = (state_q == STOP) && bit_done
                   && (bit_q == LAST_STOP);
  assign o_ready = ((state_q == IDLE) || last_stop) && !i_reset;
  assign hs      = i_valid && o_ready;
  assign clear   = hs || (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_tx    = tx_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_clear   (clear),
    .o_bit_done(bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: ;
      START: begin
        if (bit_done) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // handshake only fires in IDLE or the final stop cycle
    if (hs) begin
      state_d = START;
      shift_d = i_data;
      bit_d   = '0;
      par_d   = (^i_data) ^ PAR_INV;
    end
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: one-stop even and two-stop odd
// instances at CLKS_PER_BIT=4.
module tb_uart_tx_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data [2];
  logic       valid [2];
  logic       ready [2];
  logic       tx [2];
  logic       busy [2];

  int vecs;
  int errs;

  uart_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB),
    .STOP_BITS(1), .PARITY_ODD(0)
  ) u_a (
    .clk    (clk),
    .i_reset(rst),
    .i_data (data[0]),
    .i_valid(valid[0]),
    .o_ready(ready[0]),
    .o_tx   (tx[0]),
    .o_busy (busy[0])
  );

  uart_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB),
    .STOP_BITS(2), .PARITY_ODD(1)
  ) u_b (
    .clk    (clk),
    .i_reset(rst),
    .i_data (data[1]),
    .i_valid(valid[1]),
    .o_ready(ready[1]),
    .o_tx   (tx[1]),
    .o_busy (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int flen(input int sel);
    return (9 + P + (sel + 1)) * CPB;
  endfunction

  // Expected line level for bit period k of a frame
  function automatic logic exp_bit(input logic [7:0] d,
                                   input int k,
                                   input int sel);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (P == 1 && k == 9) return (^d) ^ (sel == 1);
    return 1'b1;
  endfunction

  // Wait (bounded) for ready, complete the handshake, drop valid.
  task automatic send_start(input int sel, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    valid[sel] = 1'b1;
    data[sel]  = d;
    while (!ready[sel] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("hs_wait", 32'(n < 500), 1);
    @(posedge clk);
    #1 valid[sel] = 1'b0;
  endtask

  // Checks every cycle of a frame whose handshake edge just passed.
  task automatic check_frame(input int sel,
                             input logic [7:0] d,
                             input int pulse_at);
    int fl;
    fl = flen(sel);
    for (int n = 0; n < fl; n++) begin
      @(negedge clk);
      check($sformatf("tx%0d_c%0d", sel, n), 32'(tx[sel]),
            32'(exp_bit(d, n / CPB, sel)));
      check($sformatf("busy%0d_c%0d", sel, n), 32'(busy[sel]), 1);
      check($sformatf("rdy%0d_c%0d", sel, n), 32'(ready[sel]),
            32'(n == fl - 1));
      if (n == pulse_at) begin
        valid[sel] = 1'b1;
        data[sel]  = 8'h3C;
      end
      if (pulse_at >= 0 && n == pulse_at + 1)
        valid[sel] = 1'b0;
    end
  endtask

  task automatic idle_chk(input int sel, input int ncyc);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (busy[sel] || !tx[sel] || !ready[sel]) bad++;
    end
    check($sformatf("idle%0d", sel), 32'(bad), 0);
  endtask

  task automatic count_low(input int sel, input int ncyc,
                           output int low, output int high);
    low  = 0;
    high = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (!tx[sel]) begin
        if (high == 0) low++;
        else low += 1000;
      end else begin
        high++;
      end
    end
  endtask

  initial begin
    int lo, hi;
    vecs = 0;
    errs = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(ready[0]), 0);
    check("rst_tx", 32'(tx[0]), 1);
    check("rst_busy", 32'(busy[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_rdy", 32'(ready[0]), 1);
    check("rel_rdy_b", 32'(ready[1]), 1);

    send_start(0, 8'hF0);
    check_frame(0, 8'hF0, -1);
    idle_chk(0, 6);

    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'h55;
    @(posedge clk);
    #1 data[0] = 8'hA5;
    check_frame(0, 8'h55, -1);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    check_frame(0, 8'hA5, -1);
    idle_chk(0, 20);

    send_start(0, 8'hF0);
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("ab_c%0d", n), 32'(tx[0]),
            32'(exp_bit(8'hF0, n / CPB, 0)));
    end
    rst = 1'b1;
    @(negedge clk);
    check("ab_tx", 32'(tx[0]), 1);
    check("ab_busy", 32'(busy[0]), 0);
    check("ab_rdy", 32'(ready[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ab_rel", 32'(ready[0]), 1);
    idle_chk(0, 50);

    send_start(0, 8'h07);
    check_frame(0, 8'h07, -1);
    send_start(1, 8'h07);
    check_frame(1, 8'h07, -1);
    idle_chk(1, 4);

    send_start(1, 8'h00);
    count_low(1, flen(1) + 8, lo, hi);
    check("st2_low", 32'(lo), 36);
    check("st2_high", 32'(hi), 8 + P * 4 + 8);
    send_start(1, 8'h00);
    check_frame(1, 8'h00, -1);

    send_start(0, 8'h81);
    check_frame(0, 8'h81, 5);
    idle_chk(0, 60);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It serialises one DATA_W-bit word per frame onto o_tx, LSB first. Each frame is a start bit, the data bits, an optional parity bit and 1 or 2 stop bits. Words arrive over a valid/ready handshake from the SoC side, replacing the bare start-strobe interface of the previous generation. Bit timing comes from a fixed CLKS_PER_BIT divider of clk.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 2.
STOP_BITS, 1, number of stop bits; 1 or 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only meaningful when UART_TX_PARITY_EN is defined.

Ports:
clk  input  1  single clock; all logic is on its rising edge.
i_reset  input  1  synchronous, active-high reset.
i_data  input  DATA_W  word to transmit; sampled only on handshake.
i_valid  input  1  i_data is valid.
o_ready  output  1  block can accept a word this cycle.
o_tx  output  1  serial line; idles high.
o_busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Handshake occurs in a cycle where i_valid && o_ready. i_data is latched into a shift register on that edge.
- i_valid may be held high while o_ready is low. The word is then taken on the first cycle o_ready is high. There is no drop and no duplication.
- o_ready = (state==IDLE || last cycle of final stop bit) && !i_reset. It is combinational from registered state.
- States: IDLE, START, DATA, PARITY, STOP. A bit counter and a baud counter are used, with widths $clog2 of their maxima.
- IDLE: o_tx=1. On handshake go to START; o_tx drops to 0 on the next cycle (latency 1 cycle).
- START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: o_tx = shift[0] for CLKS_PER_BIT cycles per bit, shifting right each bit. After DATA_W bits go to PARITY if enabled, otherwise STOP.
- PARITY: o_tx = ^data XOR PARITY_ODD for one bit period.
- STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Back-to-back: a handshake on the last STOP cycle goes directly to START, so there is zero idle gap between frames.
- Frame length: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- Reset values, applied on the clk edge where i_reset=1: state=IDLE, o_tx=1, o_busy=0, counters=0, shift register=0. o_ready=0 while i_reset is high and 1 on the first cycle after release.
- Reset mid-frame aborts immediately: o_tx returns to 1 on the next edge, the word is lost, and no partial stop bits are sent.
- o_tx is driven from a register, so there are no glitches.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists and every frame carries a parity bit selected by PARITY_ODD.
- Undefined: no PARITY state, DATA goes directly to STOP, and PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - the state enum uart_tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - the localparam functions for counter widths;
  - the constant UART_IDLE_LEVEL = 1'b1.
- One sub-module, uart_baud_cnt, takes clk, i_reset, a clear/start input and CLKS_PER_BIT. It emits a one-cycle o_bit_done pulse at the end of each bit period and restarts on clear. The FSM and shift register stay in uart_tx_param.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=4, no parity; send 8'hF0 -> o_tx levels per bit period are 0 (start), 0,0,0,0,1,1,1,1, 1 (stop). Total 40 cycles; o_busy high throughout.
2. Hold i_valid=1 with 8'h55 then 8'hA5 -> the second word is accepted on the last stop cycle of the first. The start bit of frame 2 follows immediately, and exactly 2 frames (80 cycles) are observed.
3. Assert i_reset for 1 cycle during the 3rd data bit of 8'hF0 -> o_tx=1 and o_busy=0 on the next edge, o_ready=1 one cycle after release, and no further transitions occur.
4. UART_TX_PARITY_EN defined, PARITY_ODD=0; send 8'h07 -> parity bit = 1. With PARITY_ODD=1 -> parity bit = 0. Frame length is 44 cycles.
5. STOP_BITS=2, CLKS_PER_BIT=4; send 8'h00 -> line is low for 36 cycles, then high for 8 cycles. o_ready rises only in the final stop cycle.
6. Pulse i_valid for one cycle while o_busy=1 and withdraw it before o_ready -> no word is accepted and the line stays idle after the current frame.
